// File: rtl/uart_hex_echo.sv
// Echoes each received byte to the UART transmitter as two ASCII hex digits plus a terminator.
// Define UART_HEX_ECHO_CRLF_EN for a CR LF terminator; the default build sends a single space.
module uart_hex_echo #(
    parameter int UPPERCASE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_tx_byte,
    output logic       o_tx_dv,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_busy,
    output logic       o_overflow,
    input  logic       i_clear_ovf,
    output logic [7:0] o_last_byte
);

`ifdef UART_HEX_ECHO_CRLF_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
    localparam logic [7:0] TERM0    = 8'h0D;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
    localparam logic [7:0] TERM0    = 8'h20;
`endif
    localparam logic [7:0] TERM1 = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       full_q, full_d;
    logic [7:0] work_q, work_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       ovf_q, ovf_d;
    logic [7:0] last_q, last_d;
    logic [7:0] char_cur;
    logic       tx_dv;
    logic       drain;

    // 0x37 + n gives 'A'..'F' for n=10..15; 0x57 + n gives 'a'..'f'
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else if (UPPERCASE != 0)
            return 8'h37 + {4'h0, n};
        else
            return 8'h57 + {4'h0, n};
    endfunction

    always_comb begin
        case (idx_q)
            2'd0:    char_cur = hex_char(work_q[7:4]);
            2'd1:    char_cur = hex_char(work_q[3:0]);
            2'd2:    char_cur = TERM0;
            default: char_cur = TERM1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        full_d    = full_q;
        work_d    = work_q;
        idx_d     = idx_q;
        tx_byte_d = tx_byte_q;
        ovf_d     = ovf_q;
        last_d    = last_q;
        tx_dv     = 1'b0;
        drain     = 1'b0;

        case (state_q)
            IDLE: begin
                if (full_q) begin
                    work_d  = hold_q;
                    drain   = 1'b1;
                    idx_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_dv = ~i_tx_active;
                if (tx_dv) begin
                    tx_byte_d = char_cur;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A drop in the same cycle as a clear must leave the flag set
        if (i_clear_ovf)
            ovf_d = 1'b0;
        if (drain)
            full_d = 1'b0;
        if (i_rx_valid) begin
            if (!full_q || drain) begin
                hold_d = i_rx_byte;
                full_d = 1'b1;
                last_d = i_rx_byte;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            full_q    <= 1'b0;
            work_q    <= '0;
            idx_q     <= '0;
            tx_byte_q <= '0;
            ovf_q     <= 1'b0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            work_q    <= work_d;
            idx_q     <= idx_d;
            tx_byte_q <= tx_byte_d;
            ovf_q     <= ovf_d;
            last_q    <= last_d;
        end
    end

    assign o_tx_dv     = tx_dv;
    assign o_tx_byte   = (state_q == SEND) ? char_cur : tx_byte_q;
    assign o_busy      = (state_q != IDLE) || full_q;
    assign o_overflow  = ovf_q;
    assign o_last_byte = last_q;

endmodule

// File: tb/tb_uart_hex_echo.sv
// Directed bench for uart_hex_echo: an uppercase and a lowercase instance, each with a transmitter model.
module tb_uart_hex_echo;

`ifdef UART_HEX_ECHO_CRLF_EN
    localparam int         N     = 4;
    localparam logic [7:0] TERM0 = 8'h0D;
`else
    localparam int         N     = 3;
    localparam logic [7:0] TERM0 = 8'h20;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_byte_u, tx_byte_u, last_u;
    logic       rx_valid_u, dv_u, act_m_u, done_u, busy_u, ovf_u, clr_u, hold_act;
    logic [7:0] rx_byte_l, tx_byte_l, last_l;
    logic       rx_valid_l, dv_l, act_m_l, done_l, busy_l, ovf_l, clr_l;
    logic       tx_active_u;
    logic [7:0] cap_u[$], cap_l[$];
    int         dvc_u[$];
    int         rem_u, rem_l, k_u;

    assign tx_active_u = act_m_u | hold_act;

    uart_hex_echo #(.UPPERCASE(1)) dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte(rx_byte_u), .i_rx_valid(rx_valid_u),
        .o_tx_byte(tx_byte_u), .o_tx_dv(dv_u), .i_tx_active(tx_active_u), .i_tx_done(done_u),
        .o_busy(busy_u), .o_overflow(ovf_u), .i_clear_ovf(clr_u), .o_last_byte(last_u)
    );

    uart_hex_echo #(.UPPERCASE(0)) dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_byte(rx_byte_l), .i_rx_valid(rx_valid_l),
        .o_tx_byte(tx_byte_l), .o_tx_dv(dv_l), .i_tx_active(act_m_l), .i_tx_done(done_l),
        .o_busy(busy_l), .o_overflow(ovf_l), .i_clear_ovf(clr_l), .o_last_byte(last_l)
    );

    // Transmitter models: accept on dv, stay active, pulse done 10 cycles after dv
    initial begin : tx_model_u
        logic       s;
        logic [7:0] b;
        int         c;
        act_m_u = 1'b0; done_u = 1'b0; rem_u = 0;
        forever begin
            @(negedge clk); s = dv_u; b = tx_byte_u; c = cyc;
            @(posedge clk); #1;
            if (!rst_n) begin
                act_m_u = 1'b0; done_u = 1'b0; rem_u = 0;
            end else begin
                done_u = 1'b0;
                if (s) begin
                    cap_u.push_back(b); dvc_u.push_back(c);
                    act_m_u = 1'b1; rem_u = 9;
                end else if (rem_u > 0) begin
                    rem_u = rem_u - 1;
                    if (rem_u == 0) begin done_u = 1'b1; act_m_u = 1'b0; end
                end
            end
        end
    end

    initial begin : tx_model_l
        logic       s;
        logic [7:0] b;
        act_m_l = 1'b0; done_l = 1'b0; rem_l = 0;
        forever begin
            @(negedge clk); s = dv_l; b = tx_byte_l;
            @(posedge clk); #1;
            if (!rst_n) begin
                act_m_l = 1'b0; done_l = 1'b0; rem_l = 0;
            end else begin
                done_l = 1'b0;
                if (s) begin
                    cap_l.push_back(b); act_m_l = 1'b1; rem_l = 9;
                end else if (rem_l > 0) begin
                    rem_l = rem_l - 1;
                    if (rem_l == 0) begin done_l = 1'b1; act_m_l = 1'b0; end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] q[$], input logic [7:0] hi,
                             input logic [7:0] lo);
        logic [7:0] exp[4];
        exp[0] = hi; exp[1] = lo; exp[2] = TERM0; exp[3] = 8'h0A;
        check({tag, "_count"}, q.size(), N);
        for (int i = 0; i < N; i++)
            if (i < q.size())
                check($sformatf("%s_ch%0d", tag, i), q[i], exp[i]);
    endtask

    task automatic send_u(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte_u = b; rx_valid_u = 1'b1; k_u = cyc;
        @(posedge clk); #1;
        rx_valid_u = 1'b0;
    endtask

    task automatic wait_cap_u(input string tag, input int n);
        for (int i = 0; i < 3000 && cap_u.size() < n; i++) @(negedge clk);
        if (cap_u.size() < n) check({tag, "_timeout"}, cap_u.size(), n);
    endtask

    task automatic wait_idle_u(input string tag);
        for (int i = 0; i < 3000 && (busy_u || act_m_u || rem_u != 0); i++) @(negedge clk);
        check({tag, "_idle"}, busy_u, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; hold_act = 1'b0;
        rx_byte_u = '0; rx_valid_u = 1'b0; clr_u = 1'b0;
        rx_byte_l = '0; rx_valid_l = 1'b0; clr_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txbyte", tx_byte_u, 8'h00);
        check("rst_dv", dv_u, 1'b0);
        check("rst_busy", busy_u, 1'b0);
        check("rst_ovf", ovf_u, 1'b0);
        check("rst_last", last_u, 8'h00);
        rst_n = 1'b1;

        // 0x3A on the uppercase instance: latency, spacing, busy release
        send_u(8'h3A);
        wait_cap_u("b3a", N);
        for (int i = 0; i < 50 && !done_u; i++) @(negedge clk);
        check("b3a_busy_at_done", busy_u, 1'b1);
        @(negedge clk);
        check("b3a_busy_after", busy_u, 1'b0);
        check("b3a_latency", dvc_u[0], k_u + 2);
        check("b3a_gap", dvc_u[1] - dvc_u[0], 11);
        check_seq("b3a", cap_u, 8'h33, 8'h41);
        check("b3a_last", last_u, 8'h3A);

        // 0xBF on the lowercase instance
        @(posedge clk); #1;
        rx_byte_l = 8'hBF; rx_valid_l = 1'b1;
        @(posedge clk); #1;
        rx_valid_l = 1'b0;
        for (int i = 0; i < 3000 && (cap_l.size() < N || busy_l || rem_l != 0); i++) @(negedge clk);
        check_seq("bbf", cap_l, 8'h62, 8'h66);

        // Three back-to-back strobes: third is dropped
        wait_idle_u("pre3");
        cap_u.delete(); dvc_u.delete();
        @(posedge clk); #1; rx_byte_u = 8'h11; rx_valid_u = 1'b1;
        @(posedge clk); #1; rx_byte_u = 8'h22;
        @(posedge clk); #1; rx_byte_u = 8'h33;
        @(posedge clk); #1; rx_valid_u = 1'b0;
        @(negedge clk);
        check("ovf_set", ovf_u, 1'b1);
        check("ovf_last", last_u, 8'h22);
        wait_cap_u("b3x", 2 * N);
        wait_idle_u("b3x");
        check("b3x_count", cap_u.size(), 2 * N);
        check("b3x_c0", cap_u[0], 8'h31);
        check("b3x_c1", cap_u[1], 8'h31);
        check("b3x_cN", cap_u[N], 8'h32);
        check("b3x_cN1", cap_u[N + 1], 8'h32);
        check("ovf_sticky", ovf_u, 1'b1);
        @(posedge clk); #1; clr_u = 1'b1;
        @(posedge clk); #1; clr_u = 1'b0;
        @(negedge clk);
        check("ovf_clear", ovf_u, 1'b0);

        // Transmitter busy while SEND is pending
        cap_u.delete(); dvc_u.delete();
        @(posedge clk); #1; hold_act = 1'b1;
        send_u(8'h77);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (dv_u) seen++;
            end
            check("hold_dv_count", seen, 0);
        end
        check("hold_busy", busy_u, 1'b1);
        @(posedge clk); #1; hold_act = 1'b0;
        @(negedge clk);
        check("hold_dv_rise", dv_u, 1'b1);
        @(negedge clk);
        check("hold_dv_fall", dv_u, 1'b0);
        wait_cap_u("b77", N);
        wait_idle_u("b77");
        check_seq("b77", cap_u, 8'h37, 8'h37);

        // Byte 0x00
        cap_u.delete(); dvc_u.delete();
        send_u(8'h00);
        wait_cap_u("b00", N);
        wait_idle_u("b00");
        check_seq("b00", cap_u, 8'h30, 8'h30);

        // Reset between the second dv and its done
        cap_u.delete(); dvc_u.delete();
        send_u(8'hC3);
        wait_cap_u("bc3", 2);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_dv", dv_u, 1'b0);
        check("mrst_txbyte", tx_byte_u, 8'h00);
        check("mrst_busy", busy_u, 1'b0);
        check("mrst_last", last_u, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cap_u.delete(); dvc_u.delete();
        send_u(8'h5A);
        wait_cap_u("b5a", N);
        wait_idle_u("b5a");
        check("b5a_latency", dvc_u[0], k_u + 2);
        check_seq("b5a", cap_u, 8'h35, 8'h41);
        check("b5a_last", last_u, 8'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
